// File: rtl/logic_op_pkg.sv
// Shared op-code encoding for the logic_op_pipe datapath.
package logic_op_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_NAND = 3'd1;
    localparam op_t OP_OR   = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_PASS = 3'd6;
    localparam op_t OP_ILL  = 3'd7;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational N-operand bitwise logic unit; the illegal op yields all zeros.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] operands_i,
    input  op_t                     op_i,
    output logic [WIDTH-1:0]        result_o
);

    logic [WIDTH-1:0] acc_and;
    logic [WIDTH-1:0] acc_or;
    logic [WIDTH-1:0] acc_xor;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        acc_and  = '1;
        acc_or   = '0;
        acc_xor  = '0;
        result_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            acc_and = acc_and & operands_i[k*WIDTH +: WIDTH];
            acc_or  = acc_or  | operands_i[k*WIDTH +: WIDTH];
            acc_xor = acc_xor ^ operands_i[k*WIDTH +: WIDTH];
        end
        case (op_i)
            OP_AND:  result_o = acc_and;
            OP_NAND: result_o = ~acc_and;
            OP_OR:   result_o = acc_or;
            OP_NOR:  result_o = ~acc_or;
            OP_XOR:  result_o = acc_xor;
            OP_XNOR: result_o = ~acc_xor;
            OP_PASS: result_o = operands_i[WIDTH-1:0];
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage registered logic unit with valid/ready flow control, a sticky
// illegal-op flag and a wrapping count of delivered results.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  op_t                     in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_red,
    output logic                    err_op,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        txn_cnt
);

    logic                    s1_v_q;
    logic [NUM_IN*WIDTH-1:0] s1_data_q;
    op_t                     s1_op_q;
    logic                    s2_v_q;
    logic [WIDTH-1:0]        out_data_q;
    logic                    out_red_q;
    logic                    err_op_q, err_op_d;
    logic [CNT_W-1:0]        txn_cnt_q, txn_cnt_d;

    logic                    s1_adv, s2_adv, accept;
    logic [WIDTH-1:0]        result;

    assign s2_adv   = !s2_v_q | out_ready;
    assign s1_adv   = !s1_v_q | s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid & s1_adv;

    // Operands are only captured on accept, so idle-cycle X never enters the pipe.
    // NOTE: payload registers carry no reset; the valid bit qualifies them, so their content is irrelevant until loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data_q <= in_data;
            s1_op_q   <= in_op;
        end
    end

    logic_op_unit #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_unit (
        .operands_i (s1_data_q),
        .op_i       (s1_op_q),
        .result_o   (result)
    );

    always_comb begin
        err_op_d = err_op_q;
        if (err_clr)
            err_op_d = 1'b0;
        if (accept && in_op == OP_ILL)
            err_op_d = 1'b1;
        txn_cnt_d = txn_cnt_q;
        if (s2_v_q && out_ready)
            txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            out_data_q <= '0;
            out_red_q  <= 1'b0;
            err_op_q   <= 1'b0;
            txn_cnt_q  <= '0;
        end else begin
            if (s1_adv)
                s1_v_q <= in_valid;
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    out_data_q <= result;
                    out_red_q  <= &result;
                end
            end
            err_op_q  <= err_op_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;
    assign out_red   = out_red_q;
    assign err_op    = err_op_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench: a 2-operand/16-bit-count instance and a 3-operand/4-bit-count instance.
module tb_logic_op_pipe;
    import logic_op_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_red, a_err_op, a_err_clr;
    logic [15:0] a_in_data;
    op_t         a_in_op;
    logic [7:0]  a_out_data;
    logic [15:0] a_txn_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_red, b_err_op, b_err_clr;
    logic [23:0] b_in_data;
    op_t         b_in_op;
    logic [7:0]  b_out_data;
    logic [3:0]  b_txn_cnt;

    logic_op_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_red(a_out_red),
        .err_op(a_err_op), .err_clr(a_err_clr), .txn_cnt(a_txn_cnt)
    );

    logic_op_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_red(b_out_red),
        .err_op(b_err_op), .err_clr(b_err_clr), .txn_cnt(b_txn_cnt)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        op_t         op;
        logic [15:0] data;
        logic [7:0]  exp_d;
        logic        exp_r;
    } vec2_t;

    typedef struct {
        op_t         op;
        logic [23:0] data;
        logic [7:0]  exp_d;
        logic        exp_r;
    } vec3_t;

    vec2_t      vecs[10];
    vec3_t      vecs3[6];
    logic [7:0] bp_exp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_in_valid = 1'b0; a_in_data = '0; a_in_op = OP_AND; a_out_ready = 1'b1; a_err_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_op = OP_AND; b_out_ready = 1'b1; b_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        int sent, got;
        bit have_held;
        logic [7:0] held;

        // operand 0 sits in the low byte
        vecs[0] = '{OP_AND,  16'hCCF0, 8'hC0, 1'b0};
        vecs[1] = '{OP_NAND, 16'hCCF0, 8'h3F, 1'b0};
        vecs[2] = '{OP_OR,   16'hCCF0, 8'hFC, 1'b0};
        vecs[3] = '{OP_NOR,  16'hCCF0, 8'h03, 1'b0};
        vecs[4] = '{OP_XOR,  16'hCCF0, 8'h3C, 1'b0};
        vecs[5] = '{OP_XNOR, 16'hCCF0, 8'hC3, 1'b0};
        vecs[6] = '{OP_PASS, 16'hCCF0, 8'hF0, 1'b0};
        vecs[7] = '{OP_AND,  16'hFFFF, 8'hFF, 1'b1};
        vecs[8] = '{OP_XNOR, 16'h5A5A, 8'hFF, 1'b1};
        vecs[9] = '{OP_OR,   16'h0000, 8'h00, 1'b0};

        vecs3[0] = '{OP_AND,  24'hFFFFFF, 8'hFF, 1'b1};
        vecs3[1] = '{OP_NAND, 24'hFFFFFF, 8'h00, 1'b0};
        vecs3[2] = '{OP_AND,  24'hFEFFFF, 8'hFE, 1'b0};
        vecs3[3] = '{OP_XOR,  24'h040201, 8'h07, 1'b0};
        vecs3[4] = '{OP_OR,   24'h800000, 8'h80, 1'b0};
        vecs3[5] = '{OP_PASS, 24'hAABBCC, 8'hCC, 1'b0};

        bp_exp[0] = 8'h11; bp_exp[1] = 8'h10; bp_exp[2] = 8'h13; bp_exp[3] = 8'h12;

        // Reset state, observed while rst_n is still low
        idle_inputs();
        rst_n = 1'b0;
        tick();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data",  a_out_data, 0);
        check("rst_out_red",   a_out_red, 0);
        check("rst_err_op",    a_err_op, 0);
        check("rst_txn_cnt",   a_txn_cnt, 0);
        check("rst_b_txn_cnt", b_txn_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  a_in_ready, 1);

        // Back-to-back truth table; result of vector i is visible after the edge following its accept edge
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                a_in_valid = 1'b1;
                a_in_op    = vecs[i].op;
                a_in_data  = vecs[i].data;
                #1 check($sformatf("tt_in_ready[%0d]", i), a_in_ready, 1);
            end else begin
                a_in_valid = 1'b0;
                a_in_data  = 'x;
                a_in_op    = 'x;
            end
            tick();
            if (i >= 1) begin
                check($sformatf("tt_valid[%0d]", i-1), a_out_valid, 1);
                check($sformatf("tt_data[%0d]",  i-1), a_out_data, vecs[i-1].exp_d);
                check($sformatf("tt_red[%0d]",   i-1), a_out_red,  vecs[i-1].exp_r);
            end
        end
        tick();
        check("tt_drained_valid", a_out_valid, 0);
        check("tt_txn_cnt",       a_txn_cnt, 10);
        check("tt_err_op_clear",  a_err_op, 0);

        // Three-operand instance, one item at a time
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_op    = vecs3[i].op;
            b_in_data  = vecs3[i].data;
            tick();
            b_in_valid = 1'b0;
            tick();
            check($sformatf("n3_valid[%0d]", i), b_out_valid, 1);
            check($sformatf("n3_data[%0d]",  i), b_out_data, vecs3[i].exp_d);
            check($sformatf("n3_red[%0d]",   i), b_out_red,  vecs3[i].exp_r);
        end

        // Backpressure: sink stalls for the first 5 cycles while 4 items are offered
        do_reset();
        sent = 0;
        got = 0;
        have_held = 0;
        held = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            a_out_ready = (c >= 5);
            if (sent < 4) begin
                a_in_valid = 1'b1;
                a_in_op    = OP_XOR;
                a_in_data  = {8'h01, 8'(8'h10 + sent)};
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (c == 4) begin
                check("bp_in_ready_stalled", a_in_ready, 0);
                check("bp_accepts_before_stall", sent, 2);
            end
            if (!a_out_ready && a_out_valid) begin
                if (!have_held) begin
                    held = a_out_data;
                    have_held = 1;
                end else begin
                    check($sformatf("bp_hold[%0d]", c), a_out_data, held);
                end
            end
            if (a_out_valid && a_out_ready) begin
                check($sformatf("bp_order[%0d]", got), a_out_data, bp_exp[got]);
                got++;
            end
            if (a_in_valid && a_in_ready)
                sent++;
            tick();
        end
        check("bp_delivered", got, 4);
        check("bp_held_first", held, bp_exp[0]);
        check("bp_txn_cnt", a_txn_cnt, 4);
        a_in_valid = 1'b0;

        // Illegal op accepted together with err_clr: the set wins
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_op     = OP_ILL;
        a_in_data   = 16'hFFFF;
        a_err_clr   = 1'b1;
        tick();
        check("ill_err_set", a_err_op, 1);
        a_in_valid = 1'b0;
        a_err_clr  = 1'b0;
        tick();
        check("ill_valid", a_out_valid, 1);
        check("ill_data",  a_out_data, 0);
        check("ill_red",   a_out_red, 0);
        check("ill_err_sticky", a_err_op, 1);
        tick();
        check("ill_err_still", a_err_op, 1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        check("ill_err_cleared", a_err_op, 0);
        check("ill_txn_cnt", a_txn_cnt, 5);

        // Reset asserted with two items in flight and err_op set
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_op     = OP_ILL;
        a_in_data   = 16'h1234;
        tick();
        a_in_op   = OP_AND;
        a_in_data = 16'hFFFF;
        tick();
        check("mid_pre_valid", a_out_valid, 1);
        check("mid_pre_err",   a_err_op, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_err",   a_err_op, 0);
        check("mid_rst_txn",   a_txn_cnt, 0);
        check("mid_rst_data",  a_out_data, 0);
        idle_inputs();
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("mid_dropped_valid", a_out_valid, 0);
        check("mid_dropped_txn",   a_txn_cnt, 0);

        // 4-bit counter wraps after 16 handshakes
        do_reset();
        b_in_valid = 1'b1;
        b_in_op    = OP_AND;
        b_in_data  = 24'h0F0F0F;
        for (int k = 0; k < 17; k++)
            tick();
        check("wrap_cnt_15", b_txn_cnt, 15);
        b_in_valid = 1'b0;
        for (int k = 0; k < 4; k++)
            tick();
        check("wrap_cnt_1", b_txn_cnt, 1);
        check("wrap_drained", b_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
